// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder using a single full-adder cell and a carry flop.
// Operands are shifted through the cell LSB first, one bit per clock. The result is
// {cout,sum} = a + b + cin. It is ready WIDTH cycles after the start is accepted.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input. When sub=1, the adder
// computes a - b as a + ~b + 1, and cout=1 means no borrow.
//
// Ports:
//   clk    in  1      clock, rising edge
//   rst    in  1      synchronous active-high reset
//   start  in  1      request, sampled only in IDLE or DONE
//   a, b   in  WIDTH  operands, captured on accepted start
//   cin    in  1      carry-in, captured on accepted start
//   sub    in  1      (SERIAL_ADDER_SUB_EN only) subtract select, captured on accepted start
//   busy   out 1      high while bits are being processed
//   done   out 1      one-cycle pulse, sum/cout valid
//   sum    out WIDTH  result, held until the next result is loaded
//   cout   out 1      final carry out, held like sum
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic [WIDTH-1:0] sum_sr_next;

    // The single full-adder cell.
    assign fa_sum  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_cout = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    assign sum_sr_next = {fa_sum, sum_sr_q[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StShift;
                    a_sr_d  = a;
                    b_sr_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                // start is deliberately ignored here.
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                sum_sr_d = sum_sr_next;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    // The result register is loaded only here, so sum never shows partial bits.
                    res_d   = sum_sr_next;
                    cout_d  = fa_cout;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);
    assign sum  = res_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder with WIDTH=8.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled at the same point.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(
        .WIDTH(WIDTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub  (sub),
`endif
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents operands and pulses start. On return, the start-sampling edge (edge 0) has passed.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic c,
                         input logic s);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = c;
        sub   = s;
        step();
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        sub   = 1'b0;
    endtask

    // Advances until done is seen, with a bounded number of cycles. Counts busy cycles on the way.
    task automatic wait_done(output int busy_cycles, output bit got_done, output bit overlap);
        busy_cycles = 0;
        got_done    = 1'b0;
        overlap     = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (busy && done) overlap = 1'b1;
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({busy, done, sum, cout} !== 11'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: busy=%b done=%b sum=%h cout=%b, required all 0",
                         i, busy, done, sum, cout);
            end
            step();
        end
    endtask

    task automatic test_add();
        int bc;
        bit gd, ov;
        issue(8'h35, 8'h4A, 1'b0, 1'b0);
        wait_done(bc, gd, ov);
        n_checks++;
        if (!gd) begin
            n_fail++;
            $display("FAIL add_timeout: done not seen, required within 20 cycles");
        end
        n_checks++;
        if (bc !== 8) begin
            n_fail++;
            $display("FAIL add_busy_cycles: got %0d, required 8", bc);
        end
        n_checks++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL add_busy_done_overlap: busy and done high together");
        end
        n_checks++;
        if ({cout, sum} !== 9'h07F) begin
            n_fail++;
            $display("FAIL add_result: cout=%b sum=%h, required cout=0 sum=7f", cout, sum);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done_pulse: done=%b busy=%b after pulse, required 0 0", done, busy);
        end
        n_checks++;
        if ({cout, sum} !== 9'h07F) begin
            n_fail++;
            $display("FAIL add_hold: cout=%b sum=%h, required cout=0 sum=7f", cout, sum);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int bc;
        bit gd, ov;
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(bc, gd, ov);
        n_checks++;
        if (!gd || {cout, sum} !== 9'h100) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b cout=%b sum=%h, required 1 1 00", gd, cout, sum);
        end
        // Issue the next operation in the DONE cycle itself.
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b done=%b, required 1 0", busy, done);
        end
        n_checks++;
        if ({cout, sum} !== 9'h100) begin
            n_fail++;
            $display("FAIL b2b_hold_during_shift: cout=%b sum=%h, required 1 00", cout, sum);
        end
        wait_done(bc, gd, ov);
        n_checks++;
        if (!gd || bc !== 8 || ov) begin
            n_fail++;
            $display("FAIL b2b_second_timing: done=%b busy_cycles=%0d overlap=%b, required 1 8 0",
                     gd, bc, ov);
        end
        n_checks++;
        if ({cout, sum} !== 9'h1FF) begin
            n_fail++;
            $display("FAIL b2b_second_result: cout=%b sum=%h, required 1 ff", cout, sum);
        end
        step();
    endtask

    task automatic test_start_ignored();
        int bc;
        bit gd, ov;
        issue(8'h0F, 8'h01, 1'b0, 1'b0);
        step();
        step();
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        step();
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        wait_done(bc, gd, ov);
        n_checks++;
        if (!gd || bc !== 5) begin
            n_fail++;
            $display("FAIL ignore_timing: done=%b remaining_busy=%0d, required 1 5", gd, bc);
        end
        n_checks++;
        if ({cout, sum} !== 9'h010) begin
            n_fail++;
            $display("FAIL ignore_result: cout=%b sum=%h, required 0 10", cout, sum);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int bc;
        bit gd, ov;
        bit saw_done;
        issue(8'h0F, 8'h01, 1'b0, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, sum, cout} !== 11'b0) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b done=%b sum=%h cout=%b, required all 0",
                     busy, done, sum, cout);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) saw_done = 1'b1;
            step();
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_done: activity seen after reset, required none");
        end
        issue(8'h80, 8'h80, 1'b0, 1'b0);
        wait_done(bc, gd, ov);
        n_checks++;
        if (!gd || {cout, sum} !== 9'h100) begin
            n_fail++;
            $display("FAIL midreset_next_op: done=%b cout=%b sum=%h, required 1 1 00",
                     gd, cout, sum);
        end
        step();
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int bc;
        bit gd, ov;
        issue(8'h10, 8'h01, 1'b0, 1'b1);
        wait_done(bc, gd, ov);
        n_checks++;
        if (!gd || {cout, sum} !== 9'h10F) begin
            n_fail++;
            $display("FAIL sub_no_borrow: done=%b cout=%b sum=%h, required 1 1 0f", gd, cout, sum);
        end
        step();
        // cin=1 must be ignored when subtracting.
        issue(8'h01, 8'h02, 1'b1, 1'b1);
        wait_done(bc, gd, ov);
        n_checks++;
        if (!gd || {cout, sum} !== 9'h0FF) begin
            n_fail++;
            $display("FAIL sub_borrow: done=%b cout=%b sum=%h, required 1 0 ff", gd, cout, sum);
        end
        step();
        issue(8'h10, 8'h01, 1'b1, 1'b0);
        wait_done(bc, gd, ov);
        n_checks++;
        if (!gd || {cout, sum} !== 9'h012) begin
            n_fail++;
            $display("FAIL sub0_add: done=%b cout=%b sum=%h, required 1 0 12", gd, cout, sum);
        end
        step();
    endtask
`endif

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        sub   = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
